sprite_plot_sequencer: RTL

Serialises the per-frame erase/move/draw passes of up to NUM_SPRITES sprite drawers (birds, hunter) onto the single pixel-plot port of vga_adapter. Sits between the bird/hunter draw FSMs and vga_adapter. It replaces the per-sprite state ladder in the top level with one parameterised sequencer. On each frame tick it visits every enabled sprite in index order: erase at the old position, pulse a move, then redraw in the sprite's colour.

---
 rtl/duck_hunt_pkg.sv | 23 ++
 rtl/sprite_plot_sequencer_if.sv | 28 ++
 rtl/sprite_index_scan.sv | 24 ++
 rtl/sprite_plot_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/duck_hunt_pkg.sv
// Shared types and constants for the duck-hunt display path: sequencer states, screen size,
// default sprite colours and the plot watchdog limit.
package duck_hunt_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StScan,
      StStartErase,
      StErase,
      StMove,
      StStartDraw,
      StDraw,
      StDone
   } seq_state_e;

   localparam logic [2:0]  BG_COLOUR      = 3'b000;
   localparam int unsigned SCREEN_W       = 160;
   localparam int unsigned SCREEN_H       = 120;
   localparam logic [2:0]  BIRD_COLOUR    = 3'b111;
   localparam logic [2:0]  HUNTER_COLOUR  = 3'b001;
   localparam logic [7:0]  TIMEOUT_CYCLES = 8'd255;

endpackage

// File: rtl/sprite_plot_sequencer_if.sv
// Drawer handshake and vga_adapter pixel port of the sprite plot sequencer.
interface sprite_plot_sequencer_if #(
   parameter int unsigned NUM_SPRITES = 7,
   parameter int unsigned X_W         = 8,
   parameter int unsigned Y_W         = 7,
   parameter int unsigned COLOUR_W    = 3
);
   logic [NUM_SPRITES-1:0]     drw_start;
   logic [NUM_SPRITES-1:0]     drw_move;
   logic [NUM_SPRITES-1:0]     drw_valid;
   logic [NUM_SPRITES*X_W-1:0] drw_x;
   logic [NUM_SPRITES*Y_W-1:0] drw_y;
   logic [NUM_SPRITES-1:0]     drw_done;
   logic [X_W-1:0]             x;
   logic [Y_W-1:0]             y;
   logic [COLOUR_W-1:0]        colour;
   logic                       plot;

   modport master (
      output drw_start, drw_move, x, y, colour, plot,
      input  drw_valid, drw_x, drw_y, drw_done
   );

   modport slave (
      input  drw_start, drw_move, x, y, colour, plot,
      output drw_valid, drw_x, drw_y, drw_done
   );
endinterface

// File: rtl/sprite_index_scan.sv
// Combinational search for the lowest enabled sprite slot at or above idx.
module sprite_index_scan #(
   parameter int unsigned NUM_SPRITES = 7,
   parameter int unsigned IDX_W       = 3
) (
   input  logic [NUM_SPRITES-1:0] sprite_en,
   input  logic [IDX_W-1:0]       idx,
   output logic                   found,
   output logic [IDX_W-1:0]       next_idx
);

   // Walk downwards so the lowest qualifying slot is the last one written.
   always_comb begin
      found    = 1'b0;
      next_idx = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (sprite_en[i] && (i >= int'(idx))) begin
            found    = 1'b1;
            next_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/sprite_plot_sequencer.sv
// Serialises per-frame erase/move/draw passes of the sprite drawers onto one pixel port.
// Optional PLOT_TIMEOUT_EN adds a pass watchdog and a sticky timeout output.
module sprite_plot_sequencer
   import duck_hunt_pkg::*;
#(
   parameter int unsigned NUM_SPRITES = 7,
   parameter int unsigned X_W         = 8,
   parameter int unsigned Y_W         = 7,
   parameter int unsigned COLOUR_W    = 3
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            frame_tick,
   input  logic [NUM_SPRITES-1:0]          sprite_en,
   input  logic [NUM_SPRITES*COLOUR_W-1:0] sprite_colour,
   sprite_plot_sequencer_if.master         bus,
   output logic                            busy,
   output logic                            frame_done,
`ifdef PLOT_TIMEOUT_EN
   output logic                            timeout,
`endif
   output logic                            overrun
);

   localparam int unsigned IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

   seq_state_e state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [X_W-1:0]         x_q, x_d;
   logic [Y_W-1:0]         y_q, y_d;
   logic [COLOUR_W-1:0]    colour_q, colour_d;
   logic                   plot_q, plot_d;
   logic                   busy_q, frame_done_q, overrun_q;
   logic [NUM_SPRITES-1:0] start_q, start_d, move_q, move_d;

   logic                   found;
   logic [IDX_W-1:0]       next_idx;
   logic                   in_pass, pass_done, sel_valid, sel_done;
   logic [X_W-1:0]         sel_x;
   logic [Y_W-1:0]         sel_y;
   logic [COLOUR_W-1:0]    sel_colour;

   sprite_index_scan #(
      .NUM_SPRITES(NUM_SPRITES),
      .IDX_W      (IDX_W)
   ) u_scan (
      .sprite_en(sprite_en),
      .idx      (idx_q),
      .found    (found),
      .next_idx (next_idx)
   );

   assign in_pass    = (state_q == StErase) || (state_q == StDraw);
   assign sel_valid  = bus.drw_valid[idx_q];
   assign sel_done   = bus.drw_done[idx_q];
   assign sel_x      = bus.drw_x[int'(idx_q)*X_W +: X_W];
   assign sel_y      = bus.drw_y[int'(idx_q)*Y_W +: Y_W];
   assign sel_colour = (state_q == StDraw) ? sprite_colour[int'(idx_q)*COLOUR_W +: COLOUR_W]
                                           : COLOUR_W'(BG_COLOUR);

`ifdef PLOT_TIMEOUT_EN
   logic [7:0] wdog_q, wdog_d;
   logic       wdog_hit, timeout_q;

   assign wdog_hit  = in_pass && (wdog_q == TIMEOUT_CYCLES - 8'd1);
   assign pass_done = in_pass && (sel_done || wdog_hit);
   assign wdog_d    = (in_pass && !pass_done) ? wdog_q + 8'd1 : 8'd0;

   always_ff @(posedge clock) begin
      if (reset) begin
         wdog_q    <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         wdog_q    <= wdog_d;
         timeout_q <= timeout_q | (wdog_hit && !sel_done);
      end
   end

   assign timeout = timeout_q;
`else
   // Done is only meaningful inside a pass; stale done levels elsewhere are ignored.
   assign pass_done = in_pass && sel_done;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      unique case (state_q)
         StIdle: begin
            if (frame_tick) begin
               state_d = StScan;
               idx_d   = '0;
            end
         end
         StScan: begin
            if (found) begin
               idx_d   = next_idx;
               state_d = StStartErase;
            end else begin
               state_d = StDone;
            end
         end
         StStartErase: state_d = StErase;
         StErase:      if (pass_done) state_d = StMove;
         StMove:       state_d = StStartDraw;
         StStartDraw:  state_d = StDraw;
         StDraw: begin
            if (pass_done) begin
               if (idx_q == LAST_IDX) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = StScan;
               end
            end
         end
         StDone:       state_d = StIdle;
         default:      state_d = StIdle;
      endcase
   end

   // Registered outputs are decoded from the next state so pulses line up with their state.
   always_comb begin
      start_d  = '0;
      move_d   = '0;
      plot_d   = in_pass && sel_valid;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      if ((state_d == StStartErase) || (state_d == StStartDraw)) start_d[idx_d] = 1'b1;
      if (state_d == StMove) move_d[idx_d] = 1'b1;
      if (in_pass) begin
         x_d      = sel_x;
         y_d      = sel_y;
         colour_d = sel_colour;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         colour_q     <= '0;
         plot_q       <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         start_q      <= '0;
         move_q       <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         x_q          <= x_d;
         y_q          <= y_d;
         colour_q     <= colour_d;
         plot_q       <= plot_d;
         busy_q       <= (state_d != StIdle);
         frame_done_q <= (state_d == StDone);
         overrun_q    <= overrun_q | (frame_tick && (state_q != StIdle));
         start_q      <= start_d;
         move_q       <= move_d;
      end
   end

   assign bus.drw_start = start_q;
   assign bus.drw_move  = move_q;
   assign bus.x         = x_q;
   assign bus.y         = y_q;
   assign bus.colour    = colour_q;
   assign bus.plot      = plot_q;
   assign busy          = busy_q;
   assign frame_done    = frame_done_q;
   assign overrun       = overrun_q;

endmodule
